// File: rtl/demod_segment_decision.sv
// demod_segment_decision
// Picks the largest of ten unsigned demodulation segments. It snapshots the
// segments on a rising edge of in_valid and scans them one per cycle. The
// result is held with out_valid until the downstream side accepts it.
// Optional feature macro: SEG_DECISION_MARGIN_EN. When it is defined, the block
// also tracks the second-largest value and drives margin = max - second.
module demod_segment_decision #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] segment_0,
    input  logic [WIDTH-1:0] segment_1,
    input  logic [WIDTH-1:0] segment_2,
    input  logic [WIDTH-1:0] segment_3,
    input  logic [WIDTH-1:0] segment_4,
    input  logic [WIDTH-1:0] segment_5,
    input  logic [WIDTH-1:0] segment_6,
    input  logic [WIDTH-1:0] segment_7,
    input  logic [WIDTH-1:0] segment_8,
    input  logic [WIDTH-1:0] segment_9,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [3:0]       symbol,
    output logic [WIDTH-1:0] max_value,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
`ifdef SEG_DECISION_MARGIN_EN
    ,
    output logic [WIDTH-1:0] margin
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             inValidPrev_q;
    logic [WIDTH-1:0] snap_q [10];
    logic [WIDTH-1:0] maxVal_q;
    logic [3:0]       index_q;
    logic             outValid_q;
    logic             busy_q;
    logic             overrun_q;

    logic [WIDTH-1:0] segIn [10];
    logic             riseEvent;
    logic [WIDTH-1:0] cmpVal;
    logic             greater;

    assign segIn[0] = segment_0;
    assign segIn[1] = segment_1;
    assign segIn[2] = segment_2;
    assign segIn[3] = segment_3;
    assign segIn[4] = segment_4;
    assign segIn[5] = segment_5;
    assign segIn[6] = segment_6;
    assign segIn[7] = segment_7;
    assign segIn[8] = segment_8;
    assign segIn[9] = segment_9;

    assign riseEvent = in_valid & ~inValidPrev_q;
    assign cmpVal    = snap_q[cnt_q];
    assign greater   = (cmpVal > maxVal_q);

`ifdef SEG_DECISION_MARGIN_EN
    logic [WIDTH-1:0] second_q;
    logic [WIDTH-1:0] margin_q;
    logic [WIDTH-1:0] secondNext;
    logic [WIDTH-1:0] maxNext;

    // Runner-up update for the current compare: a new max demotes the old max, otherwise the value may beat the runner-up.
    always_comb begin
        secondNext = second_q;
        maxNext    = maxVal_q;
        if (greater) begin
            secondNext = maxVal_q;
            maxNext    = cmpVal;
        end else if (cmpVal > second_q) begin
            secondNext = cmpVal;
        end
    end

    // Runner-up and margin registers; margin is latched on the last compare so it is valid together with out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            second_q <= '0;
            margin_q <= '0;
        end else if (state_q == IDLE && riseEvent) begin
            second_q <= '0;
        end else if (state_q == SCAN) begin
            second_q <= secondNext;
            if (cnt_q == 4'd9) begin
                margin_q <= maxNext - secondNext;
            end
        end
    end

    assign margin = margin_q;
`endif

    // Main FSM: capture on rising in_valid in IDLE, scan one snapshot entry per cycle, hold the result in DONE until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            inValidPrev_q <= 1'b0;
            maxVal_q      <= '0;
            index_q       <= 4'd0;
            outValid_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            inValidPrev_q <= in_valid;
            case (state_q)
                IDLE: begin
                    if (riseEvent) begin
                        for (int i = 0; i < 10; i++) begin
                            snap_q[i] <= segIn[i];
                        end
                        maxVal_q <= segIn[0];
                        index_q  <= 4'd0;
                        cnt_q    <= 4'd1;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (riseEvent) begin
                        overrun_q <= 1'b1;
                    end
                    if (greater) begin
                        maxVal_q <= cmpVal;
                        index_q  <= cnt_q;
                    end
                    if (cnt_q == 4'd9) begin
                        cnt_q      <= 4'd0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (riseEvent) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign symbol    = index_q;
    assign max_value = maxVal_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_demod_segment_decision.sv
// tb_demod_segment_decision
// Randomized and directed bench for demod_segment_decision. Expected results
// come from a sort-based reference model of the ten segment values.
// Optional feature macro: SEG_DECISION_MARGIN_EN (enables the margin checks).
module tb_demod_segment_decision;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] stim [10];
    logic         in_valid;
    logic         out_ready;
    logic [3:0]   symbol;
    logic [W-1:0] max_value;
    logic         out_valid;
    logic         busy;
    logic         overrun;
`ifdef SEG_DECISION_MARGIN_EN
    logic [W-1:0] margin;
    logic [W-1:0] expMargin;
`endif

    int           checkCount = 0;
    int           passCount  = 0;
    logic [W-1:0] expMax;
    logic [3:0]   expSym;
    logic         expOverrun;

    demod_segment_decision #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .segment_0 (stim[0]),
        .segment_1 (stim[1]),
        .segment_2 (stim[2]),
        .segment_3 (stim[3]),
        .segment_4 (stim[4]),
        .segment_5 (stim[5]),
        .segment_6 (stim[6]),
        .segment_7 (stim[7]),
        .segment_8 (stim[8]),
        .segment_9 (stim[9]),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .symbol    (symbol),
        .max_value (max_value),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SEG_DECISION_MARGIN_EN
        ,
        .margin    (margin)
`endif
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Reference model: sort the values descending; the max is the head, the margin is head minus next,
    // and the symbol is the first position holding the max.
    task automatic computeExpected();
        logic [W-1:0] sorted [$];
        bool_found: begin end
        sorted = {};
        for (int i = 0; i < 10; i++) sorted.push_back(stim[i]);
        sorted.rsort();
        expMax = sorted[0];
`ifdef SEG_DECISION_MARGIN_EN
        expMargin = sorted[0] - sorted[1];
`endif
        expSym = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (stim[i] == expMax) expSym = 4'(i);
        end
    endtask

    // Drop in_valid for a cycle, then raise it so the next rising clock edge captures
    task automatic applyStimulus();
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
    endtask

    // Count falling edges until out_valid appears, with a hard bound
    task automatic waitForDone(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic randomStim(input bit smallRange);
        for (int i = 0; i < 10; i++) begin
            stim[i] = smallRange ? W'($urandom_range(0, 3)) : W'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) stim[i] = '0;
        expOverrun = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({symbol, max_value, out_valid, busy, overrun} !== '0)
            $display("[TB] FAIL reset_outputs: got sym=%0d max=%h ov=%b busy=%b orun=%b, required all zero",
                     symbol, max_value, out_valid, busy, overrun);
        else passCount++;
`ifdef SEG_DECISION_MARGIN_EN
        checkCount++;
        if (margin !== '0) $display("[TB] FAIL reset_margin: got %h required 0", margin);
        else passCount++;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL idle_after_reset: got ov=%b busy=%b required 0/0", out_valid, busy);
        else passCount++;
    endtask

    // One full transaction with result checks; mid-scan segment scrambling exercises snapshot isolation
    task automatic runAndCheck(input string name, input bit scramble);
        int cycles;
        computeExpected();
        applyStimulus();
        if (scramble) begin
            @(negedge clk);
            randomStim(1'b0);
            waitForDone(cycles);
            cycles++;
        end else begin
            waitForDone(cycles);
        end
        checkCount++;
        if (cycles !== 10)
            $display("[TB] FAIL %s_latency: got %0d cycles required 10", name, cycles);
        else passCount++;
        checkCount++;
        if (symbol !== expSym || max_value !== expMax)
            $display("[TB] FAIL %s_result: got sym=%0d max=%h required sym=%0d max=%h",
                     name, symbol, max_value, expSym, expMax);
        else passCount++;
`ifdef SEG_DECISION_MARGIN_EN
        checkCount++;
        if (margin !== expMargin)
            $display("[TB] FAIL %s_margin: got %h required %h", name, margin, expMargin);
        else passCount++;
`endif
        checkCount++;
        if (busy !== 1'b1 || overrun !== expOverrun)
            $display("[TB] FAIL %s_flags: got busy=%b orun=%b required 1/%b", name, busy, overrun, expOverrun);
        else passCount++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkCount++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL %s_release: got ov=%b busy=%b required 0/0", name, out_valid, busy);
        else passCount++;
    endtask

    task automatic test_known_vectors();
        stim = '{32'd5, 32'd9, 32'd3, 32'd7, 32'd1, 32'd0, 32'd2, 32'd8, 32'd4, 32'd6};
        runAndCheck("vec_mixed", 1'b0);
        for (int i = 0; i < 10; i++) stim[i] = 32'h10;
        runAndCheck("vec_ties", 1'b0);
        for (int i = 0; i < 9; i++) stim[i] = 32'd1;
        stim[9] = 32'hFFFF_FFFF;
        runAndCheck("vec_unsigned", 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            randomStim(n[0]);
            runAndCheck("random", n[1]);
        end
    endtask

    task automatic test_backpressure();
        int cycles;
        randomStim(1'b0);
        computeExpected();
        applyStimulus();
        waitForDone(cycles);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkCount++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || symbol !== expSym || max_value !== expMax)
                $display("[TB] FAIL hold_%0d: got ov=%b busy=%b sym=%0d max=%h required 1/1/%0d/%h",
                         k, out_valid, busy, symbol, max_value, expSym, expMax);
            else passCount++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkCount++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL hold_release: got ov=%b busy=%b required 0/0", out_valid, busy);
        else passCount++;
    endtask

    task automatic test_overrun();
        int  cycles;
        bit  sawValid;
        randomStim(1'b0);
        computeExpected();
        applyStimulus();
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        expOverrun = 1'b1;
        checkCount++;
        if (overrun !== 1'b1) $display("[TB] FAIL overrun_set: got %b required 1", overrun);
        else passCount++;
        waitForDone(cycles);
        checkCount++;
        if (out_valid !== 1'b1 || symbol !== expSym || max_value !== expMax)
            $display("[TB] FAIL overrun_result: got ov=%b sym=%0d max=%h required 1/%0d/%h",
                     out_valid, symbol, max_value, expSym, expMax);
        else passCount++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        sawValid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid || busy) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid !== 1'b0 || overrun !== 1'b1)
            $display("[TB] FAIL held_valid_recapture: got recapture=%b orun=%b required 0/1", sawValid, overrun);
        else passCount++;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        bit sawValid;
        randomStim(1'b0);
        stim[0] = stim[0] | 32'h1;
        applyStimulus();
        repeat (5) @(negedge clk);
        checkCount++;
        if (busy !== 1'b1 || max_value === '0)
            $display("[TB] FAIL scan_busy: got busy=%b max=%h required busy=1 max nonzero", busy, max_value);
        else passCount++;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        expOverrun = 1'b0;
        checkCount++;
        if ({symbol, max_value, out_valid, busy, overrun} !== '0)
            $display("[TB] FAIL async_reset: got sym=%0d max=%h ov=%b busy=%b orun=%b required all zero",
                     symbol, max_value, out_valid, busy, overrun);
        else passCount++;
`ifdef SEG_DECISION_MARGIN_EN
        checkCount++;
        if (margin !== '0) $display("[TB] FAIL async_reset_margin: got %h required 0", margin);
        else passCount++;
`endif
        @(negedge clk);
        reset = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid || busy) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid !== 1'b0)
            $display("[TB] FAIL post_reset_idle: got activity=%b required 0", sawValid);
        else passCount++;
        randomStim(1'b1);
        runAndCheck("post_reset", 1'b0);
    endtask

    // Rising in_valid on the same edge that DONE hands back to IDLE: dropped, flags overrun
    task automatic test_done_edge_drop();
        int cycles;
        bit sawValid;
        randomStim(1'b0);
        applyStimulus();
        waitForDone(cycles);
        in_valid = 1'b0;
        @(negedge clk);
        checkCount++;
        if (overrun !== 1'b0 || out_valid !== 1'b1)
            $display("[TB] FAIL edge_drop_pre: got orun=%b ov=%b required 0/1", overrun, out_valid);
        else passCount++;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkCount++;
        if (overrun !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL edge_drop: got orun=%b ov=%b busy=%b required 1/0/0", overrun, out_valid, busy);
        else passCount++;
        sawValid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid || busy) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid !== 1'b0)
            $display("[TB] FAIL edge_drop_no_capture: got activity=%b required 0", sawValid);
        else passCount++;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_overrun();
        test_reset_mid_scan();
        test_done_edge_drop();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
